// File: rtl/otbn_keccak_plane_seq.sv
// Keccak plane sequencer: streams 5-lane planes through chi/chi+iota, or folds them into
// theta column parities and emits the D plane. OTBN_KECCAK_PLANE_SEQ_STATS_EN adds a busy-cycle counter.
module otbn_keccak_plane_seq #(
  parameter int LANEW   = 64,
  parameter int NPLANES = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         op_i,
  input  logic [LANEW-1:0]   rc_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [5*LANEW-1:0] plane_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [5*LANEW-1:0] plane_o,
  output logic               done_o,
  output logic [31:0]        busy_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [1:0] OP_THETA = 2'b00;
  localparam logic [1:0] OP_IOTA  = 2'b10;

  state_t                 state;
  logic [1:0]             op;
  logic [LANEW-1:0]       rc;
  logic [2:0]             cnt;
  logic [4:0][LANEW-1:0]  acc;
  logic                   d_loaded;

  logic [4:0][LANEW-1:0]  a, chi, d;
  logic                   is_theta, last, in_fire, out_fire;

  assign a        = plane_i;
  assign is_theta = (op == OP_THETA);
  assign last     = (cnt == 3'(NPLANES - 1));

  always_comb begin
    chi = '0;
    d   = '0;
    for (int x = 0; x < 5; x++) begin
      chi[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
      d[x]   = acc[(x + 4) % 5] ^
               {acc[(x + 1) % 5][LANEW-2:0], acc[(x + 1) % 5][LANEW-1]};
    end
    // iota only touches the first plane of a job
    if (op == OP_IOTA && cnt == 3'd0) chi[0] = chi[0] ^ rc;
  end

  assign cmd_ready_o = (state == IDLE);

  always_comb begin
    in_ready_o = 1'b0;
    if (state == RUN) in_ready_o = is_theta ? 1'b1 : (!out_valid_o || out_ready_i);
  end

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      op          <= '0;
      rc          <= '0;
      cnt         <= '0;
      acc         <= '0;
      d_loaded    <= 1'b0;
      out_valid_o <= 1'b0;
      plane_o     <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            op       <= op_i;
            rc       <= rc_i;
            cnt      <= '0;
            acc      <= '0;
            d_loaded <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (out_fire) out_valid_o <= 1'b0;
          if (in_fire) begin
            cnt <= cnt + 3'd1;
            if (is_theta) begin
              acc <= acc ^ a;
            end else begin
              plane_o     <= chi;
              out_valid_o <= 1'b1;
            end
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // theta emits its single D plane only once the output slot is empty
          if (is_theta && !d_loaded && !out_valid_o) begin
            plane_o     <= d;
            out_valid_o <= 1'b1;
            d_loaded    <= 1'b1;
          end else if (out_fire) begin
            out_valid_o <= 1'b0;
            done_o      <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OTBN_KECCAK_PLANE_SEQ_STATS_EN
  logic [31:0] busy;
  always_ff @(posedge clk_i) begin
    if (rst_i) busy <= '0;
    else if (state != IDLE && busy != 32'hFFFF_FFFF) busy <= busy + 32'd1;
  end
  assign busy_cnt_o = busy;
`else
  assign busy_cnt_o = '0;
`endif

endmodule

// File: tb/tb_otbn_keccak_plane_seq.sv
// Directed bench: three instances (64b/5 planes, 64b/2 planes, 8b/1 plane), checks sampled on negedge.
module tb_otbn_keccak_plane_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] pl(input logic [63:0] l4, l3, l2, l1, l0);
    return {l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [319:0] chi_ref(input logic [319:0] p);
    logic [4:0][63:0] a, r;
    a = p;
    for (int x = 0; x < 5; x++) r[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
    return r;
  endfunction

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RC   = 64'h8000_0000_0000_8082;

  // instance 0: LANEW=64, NPLANES=5
  logic cv0, cr0, iv0, ir0, ov0, ory0, dn0;
  logic [1:0] op0;
  logic [63:0] rc0;
  logic [319:0] pl0, po0;
  logic [31:0] bc0;
  otbn_keccak_plane_seq #(.LANEW(64), .NPLANES(5)) u0 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cv0), .cmd_ready_o(cr0), .op_i(op0), .rc_i(rc0),
    .in_valid_i(iv0), .in_ready_o(ir0), .plane_i(pl0), .out_valid_o(ov0), .out_ready_i(ory0),
    .plane_o(po0), .done_o(dn0), .busy_cnt_o(bc0));

  // instance 1: LANEW=64, NPLANES=2
  logic cv1, cr1, iv1, ir1, ov1, ory1, dn1;
  logic [1:0] op1;
  logic [63:0] rc1;
  logic [319:0] pl1, po1;
  logic [31:0] bc1;
  otbn_keccak_plane_seq #(.LANEW(64), .NPLANES(2)) u1 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cv1), .cmd_ready_o(cr1), .op_i(op1), .rc_i(rc1),
    .in_valid_i(iv1), .in_ready_o(ir1), .plane_i(pl1), .out_valid_o(ov1), .out_ready_i(ory1),
    .plane_o(po1), .done_o(dn1), .busy_cnt_o(bc1));

  // instance 2: LANEW=8, NPLANES=1
  logic cv2, cr2, iv2, ir2, ov2, ory2, dn2;
  logic [1:0] op2;
  logic [7:0] rc2;
  logic [39:0] pl2, po2;
  logic [31:0] bc2;
  otbn_keccak_plane_seq #(.LANEW(8), .NPLANES(1)) u2 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cv2), .cmd_ready_o(cr2), .op_i(op2), .rc_i(rc2),
    .in_valid_i(iv2), .in_ready_o(ir2), .plane_i(pl2), .out_valid_o(ov2), .out_ready_i(ory2),
    .plane_o(po2), .done_o(dn2), .busy_cnt_o(bc2));

  // THETA_D on u0 with plane0 lane1 = 1: expect D[0]=2, D[2]=1
  task automatic theta_job0(input string tag);
    cv0 = 1'b1; op0 = 2'b00;
    @(negedge clk);
    op0 = 2'b01;  // stray command while running must be ignored
    chk({tag, "_run_cr"}, cr0, 1'b0);
    chk({tag, "_run_ir"}, ir0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      iv0 = 1'b1;
      pl0 = (i == 0) ? pl(0, 0, 0, 1, 0) : '0;
      @(negedge clk);
      cv0 = 1'b0;
    end
    iv0 = 1'b0;
    chk({tag, "_drain_ir"}, ir0, 1'b0);
    chk({tag, "_drain_ov0"}, ov0, 1'b0);
    @(negedge clk);
    chk({tag, "_d_valid"}, ov0, 1'b1);
    chk({tag, "_d_plane"}, po0, pl(0, 0, 1, 0, 2));
    @(negedge clk);
    chk({tag, "_d_hold"}, po0, pl(0, 0, 1, 0, 2));
    chk({tag, "_no_early_done"}, dn0, 1'b0);
    ory0 = 1'b1;
    @(negedge clk);
    ory0 = 1'b0;
    chk({tag, "_done"}, dn0, 1'b1);
    chk({tag, "_ov_clr"}, ov0, 1'b0);
    chk({tag, "_idle_cr"}, cr0, 1'b1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, dn0, 1'b0);
  endtask

  // two-plane job on u1 with output always ready
  task automatic job1(input string tag, input logic [1:0] op, input logic [63:0] rc,
                      input logic [319:0] pa, pb, ea, eb);
    cv1 = 1'b1; op1 = op; rc1 = rc;
    @(negedge clk);
    cv1 = 1'b0; rc1 = '0;
    iv1 = 1'b1; pl1 = pa; ory1 = 1'b1;
    @(negedge clk);
    chk({tag, "_a_valid"}, ov1, 1'b1);
    chk({tag, "_a_plane"}, po1, ea);
    pl1 = pb;
    @(negedge clk);
    iv1 = 1'b0;
    chk({tag, "_b_plane"}, po1, eb);
    chk({tag, "_b_drain_ir"}, ir1, 1'b0);
    @(negedge clk);
    ory1 = 1'b0;
    chk({tag, "_done"}, dn1, 1'b1);
  endtask

  logic [319:0] p [5];

  initial begin
    rst = 1'b1;
    {cv0, iv0, ory0, cv1, iv1, ory1, cv2, iv2, ory2} = '0;
    op0 = '0; op1 = '0; op2 = '0; rc0 = '0; rc1 = '0; rc2 = '0;
    pl0 = '0; pl1 = '0; pl2 = '0;
    for (int i = 0; i < 5; i++)
      for (int w = 0; w < 10; w++) p[i][w*32 +: 32] = $urandom();

    repeat (2) @(negedge clk);
    chk("rst_ov", ov0, 1'b0);
    chk("rst_plane", po0, '0);
    chk("rst_done", dn0, 1'b0);
    chk("rst_busy", bc0, '0);
    chk("rst_cr", cr0, 1'b1);
    rst = 1'b0;

    // input handshake is closed in IDLE
    iv0 = 1'b1; pl0 = p[0];
    @(negedge clk);
    chk("idle_ir", ir0, 1'b0);
    @(negedge clk);
    chk("idle_ov", ov0, 1'b0);
    iv0 = 1'b0;

    theta_job0("theta");

    // CHI streaming with a 3-cycle output stall
    cv0 = 1'b1; op0 = 2'b01;
    @(negedge clk);
    cv0 = 1'b0; ory0 = 1'b1; iv0 = 1'b1; pl0 = p[0];
    @(negedge clk);
    chk("chi_p0", po0, chi_ref(p[0]));
    pl0 = p[1];
    @(negedge clk);
    chk("chi_p1_nobubble", po0, chi_ref(p[1]));
    chk("chi_p1_valid", ov0, 1'b1);
    ory0 = 1'b0; pl0 = p[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_plane", po0, chi_ref(p[1]));
      chk("stall_ir", ir0, 1'b0);
    end
    ory0 = 1'b1;
    @(negedge clk);
    chk("chi_p2", po0, chi_ref(p[2]));
    pl0 = p[3];
    @(negedge clk);
    chk("chi_p3", po0, chi_ref(p[3]));
    pl0 = p[4];
    @(negedge clk);
    iv0 = 1'b0;
    chk("chi_p4", po0, chi_ref(p[4]));
    chk("chi_drain_ir", ir0, 1'b0);
    chk("chi_no_early_done", dn0, 1'b0);
    @(negedge clk);
    ory0 = 1'b0;
    chk("chi_done", dn0, 1'b1);
    chk("chi_ov_clr", ov0, 1'b0);

    // reset in RUN after two accepted planes, then a fresh job
    cv0 = 1'b1; op0 = 2'b00;
    @(negedge clk);
    cv0 = 1'b0; iv0 = 1'b1; pl0 = p[3];
    repeat (2) @(negedge clk);
    iv0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ov", ov0, 1'b0);
    chk("midrst_cr", cr0, 1'b1);
    chk("midrst_ir", ir0, 1'b0);
    @(negedge clk);
    chk("midrst_quiet", ov0, 1'b0);
    theta_job0("theta2");

    job1("chi1", 2'b01, RC, pl(0, 0, ONES, 0, 0), '0, pl(0, 0, ONES, 0, ONES), '0);
    job1("iota", 2'b10, RC, '0, '0, pl(0, 0, 0, 0, RC), '0);
    job1("rsvd", 2'b11, RC, '0, '0, '0, '0);

    // 8-bit lanes: C[1]=0x80 rotates into bit 0 of D[0]
    cv2 = 1'b1; op2 = 2'b00;
    @(negedge clk);
    cv2 = 1'b0; iv2 = 1'b1; pl2 = 40'h00_00_00_80_00;
    @(negedge clk);
    iv2 = 1'b0;
    chk("w8_drain_ov0", ov2, 1'b0);
    @(negedge clk);
    chk("w8_valid", ov2, 1'b1);
    chk("w8_plane", po2, 40'h00_00_80_00_01);
    ory2 = 1'b1;
    @(negedge clk);
    ory2 = 1'b0;
    chk("w8_done", dn2, 1'b1);

`ifdef OTBN_KECCAK_PLANE_SEQ_STATS_EN
    chk("busy_counted", bc0 != 32'd0, 1'b1);
`else
    chk("busy_zero", bc0, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otbn_keccak_plane_seq.md
OTBN_KECCAK_PLANE_SEQ -- requirements
Module: otbn_keccak_plane_seq

Interface
REQ-001 The module SHALL have parameter LANEW, default 64, meaning lane width in bits (legal values 8, 16, 32, 64).
REQ-002 The module SHALL have parameter NPLANES, default 5, meaning planes per job (legal values 1 to 5).
REQ-003 The module SHALL use one clock, clk_i, and one reset, rst_i, which is synchronous and active-high.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 cmd_valid_i  input  1  job command valid.
REQ-007 cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-008 op_i  input  2  job op: 00 THETA_D, 01 CHI, 10 CHI_IOTA, 11 reserved (treated as CHI).
REQ-009 rc_i  input  LANEW  round constant, sampled at command accept.
REQ-010 in_valid_i / in_ready_o  input / output  1 / 1  plane input handshake.
REQ-011 plane_i  input  5*LANEW  lane x occupies bits [x*LANEW +: LANEW].
REQ-012 out_valid_o / out_ready_i  output / input  1 / 1  result handshake.
REQ-013 plane_o  output  5*LANEW  result plane, same lane packing as plane_i.
REQ-014 done_o  output  1  one-cycle pulse after the last result of a job is accepted.
REQ-015 busy_cnt_o  output  32  busy-cycle counter (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DRAIN, and reset to IDLE.
REQ-017 In IDLE: cmd_ready_o = 1; a cmd handshake latches op_i and rc_i, clears the plane counter and the parity accumulator, and moves to RUN.
REQ-018 rotl1 SHALL denote rotate-left by 1 within LANEW bits; all lane indices wrap mod 5.
REQ-019 CHI/CHI_IOTA in RUN: in_ready_o = !out_valid_o || out_ready_i; each accepted plane loads the output register next cycle with lane[x] = a[x] ^ (~a[x+1] & a[x+2]) (latency 1).
REQ-020 CHI_IOTA: rc is XORed into lane 0 of the plane with counter index 0 only.
REQ-021 THETA_D in RUN: in_ready_o = 1 and no per-plane output; the accumulator is C[x] ^= a[x] for each accepted plane.
REQ-022 The plane counter SHALL increment on every accepted plane; at NPLANES-1 accepted: CHI ops go to DRAIN; THETA_D goes to DRAIN with final C including the last plane.
REQ-023 DRAIN, THETA_D: when the output register is free, load D[x] = C[x-1] ^ rotl1(C[x+1]) once.
REQ-024 DRAIN: in_ready_o = 0; when the final result handshakes, pulse done_o and go to IDLE (cmd_ready_o = 1 the following cycle).
REQ-025 out_valid_o SHALL stay high and plane_o SHALL stay stable until out_ready_i; simultaneous accept-out and load-in SHALL occur in the same cycle without a bubble.
REQ-026 cmd_valid_i outside IDLE SHALL be ignored; in_valid_i in IDLE SHALL be ignored (in_ready_o = 0).

Reset
REQ-027 On rst_i: state = IDLE, out_valid_o = 0, plane_o = 0, done_o = 0, counter/accumulator/latched op/rc = 0, busy_cnt_o = 0; reset mid-job SHALL abort it with no further output.

Configuration
REQ-028 With OTBN_KECCAK_PLANE_SEQ_STATS_EN defined: busy_cnt_o increments by 1 each cycle the state is not IDLE, saturating at 0xFFFFFFFF and cleared only by reset.
REQ-029 Without OTBN_KECCAK_PLANE_SEQ_STATS_EN: busy_cnt_o is constant 0 and no counter flops exist.

Verification
REQ-030 THETA_D, NPLANES=5, LANEW=64, plane0 lane1 = 1 and all other lanes 0 -> one output with D[0]=2, D[2]=1, other lanes 0, then done_o.
REQ-031 CHI, one plane with a0=0, a1=0, a2=all-ones, a3=0, a4=0 -> lanes (all-ones, 0, all-ones, 0, 0) one cycle after accept.
REQ-032 CHI_IOTA, rc=0x8000000000008082, two zero planes (NPLANES=2) -> plane 0 lane0 = 0x8000000000008082, other lanes 0; plane 1 all zero.
REQ-033 CHI streaming with out_ready_i low 3 cycles -> plane_o stable, in_ready_o = 0, and no plane lost or duplicated.
REQ-034 rst_i asserted in RUN after 2 planes -> next cycle IDLE, out_valid_o = 0, and a new job produces correct results.
REQ-035 LANEW=8 THETA_D with C[1]=0x80 -> D[0]=0x01, confirming rotation wraps within the lane width.
